// File: rtl/priority_encoder_stream.sv
// Streaming priority encoder: accepts a W-bit request vector and walks its set
// bits in priority order, emitting up to LANES indices per output beat.
//
// state | meaning
// IDLE  | no vector held, in_ready high, out_valid low
// BUSY  | a beat is presented on out_*; res holds bits not yet presented
//
// res always holds the bits that remain *after* the beat currently on out_*,
// so out_last and the next beat can both be decided from res alone.
module priority_encoder_stream #(
   parameter int W     = 16,
   parameter int LANES = 2,
   parameter int DIR   = 0,
   localparam int IW   = $clog2(W)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        in_vec,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LANES*IW-1:0] out_index,
   output logic [LANES-1:0]    out_mask,
   output logic                out_last,
   output logic                out_empty
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state;
   logic [W-1:0]        res;

   logic                fire_out;
   logic                accept;
   logic [W-1:0]        src;
   logic [W-1:0]        rem;
   logic [LANES*IW-1:0] sel_index;
   logic [LANES-1:0]    sel_mask;
   logic                sel_last;
   logic                sel_empty;

   assign fire_out = out_valid && out_ready;
   assign in_ready = (state == IDLE) || (fire_out && out_last);
   assign accept   = in_valid && in_ready;

   // Pick up to LANES set bits from the next source (new vector or residual),
   // one find-first per lane, masking each winner before the next lane looks.
   always_comb begin
      src       = accept ? in_vec : res;
      rem       = src;
      sel_index = '0;
      sel_mask  = '0;
      for (int k = 0; k < LANES; k++) begin
         logic hit;
         int   pos;
         hit = 1'b0;
         pos = 0;
         for (int j = 0; j < W; j++) begin
            pos = (DIR != 0) ? (W - 1 - j) : j;
            if (!hit && rem[pos]) begin
               hit                     = 1'b1;
               sel_index[k*IW +: IW]   = IW'(pos);
               sel_mask[k]             = 1'b1;
               rem[pos]                = 1'b0;
            end
         end
      end
      sel_last  = (rem == '0);
      sel_empty = (src == '0);
   end

   // Control FSM with registered beat outputs; a new vector may be taken in
   // the same cycle the final beat of the previous one is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         res       <= '0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
         out_empty <= 1'b0;
      end else if (accept || (fire_out && !out_last)) begin
         state     <= BUSY;
         res       <= rem;
         out_valid <= 1'b1;
         out_index <= sel_index;
         out_mask  <= sel_mask;
         out_last  <= sel_last;
         out_empty <= sel_empty;
      end else if (fire_out) begin
         state     <= IDLE;
         res       <= '0;
         out_valid <= 1'b0;
         out_index <= '0;
         out_mask  <= '0;
         out_last  <= 1'b0;
         out_empty <= 1'b0;
      end
   end

   logic [LANES-1:0] mask_inc;
   assign mask_inc = out_mask + 1'b1;

   // Structural sanity on the presented beat.
   a_idle_no_valid : assert property (@(posedge clk) disable iff (!rst_n)
      (state == IDLE) |-> !out_valid);
   a_mask_contig : assert property (@(posedge clk) disable iff (!rst_n)
      (out_mask & mask_inc) == '0);

   for (genvar g = 0; g < LANES - 1; g++) begin : g_mono
      a_monotonic : assert property (@(posedge clk) disable iff (!rst_n)
         out_mask[g+1] |-> ((DIR != 0)
            ? (out_index[(g+1)*IW +: IW] < out_index[g*IW +: IW])
            : (out_index[(g+1)*IW +: IW] > out_index[g*IW +: IW])));
   end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Directed bench: one LSB-first and one MSB-first instance share stimulus.
module tb_priority_encoder_stream;

   localparam int W     = 16;
   localparam int LANES = 2;
   localparam int IW    = 4;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic [W-1:0]        in_vec;
   logic                out_ready;

   logic                in_ready0,  in_ready1;
   logic                out_valid0, out_valid1;
   logic [LANES*IW-1:0] out_index0, out_index1;
   logic [LANES-1:0]    out_mask0,  out_mask1;
   logic                out_last0,  out_last1;
   logic                out_empty0, out_empty1;

   int n_checks = 0;
   int n_errors = 0;

   priority_encoder_stream #(.W(W), .LANES(LANES), .DIR(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_vec(in_vec), .out_valid(out_valid0), .out_ready(out_ready),
      .out_index(out_index0), .out_mask(out_mask0), .out_last(out_last0),
      .out_empty(out_empty0)
   );

   priority_encoder_stream #(.W(W), .LANES(LANES), .DIR(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_vec(in_vec), .out_valid(out_valid1), .out_ready(out_ready),
      .out_index(out_index1), .out_mask(out_mask1), .out_last(out_last1),
      .out_empty(out_empty1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Beat check on the LSB-first instance.
   task automatic beat0(input string tag, input logic [7:0] idx, input logic [1:0] msk,
                        input logic lst, input logic emp);
      chk({tag, "_valid"}, 32'(out_valid0), 32'd1);
      chk({tag, "_index"}, 32'(out_index0), 32'(idx));
      chk({tag, "_mask"},  32'(out_mask0),  32'(msk));
      chk({tag, "_last"},  32'(out_last0),  32'(lst));
      chk({tag, "_empty"}, 32'(out_empty0), 32'(emp));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_vec    = '0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_out_index", 32'(out_index0), 32'd0);
      chk("rst_out_mask",  32'(out_mask0),  32'd0);
      chk("rst_out_last",  32'(out_last0),  32'd0);
      chk("rst_out_empty", 32'(out_empty0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready0), 32'd1);

      // 0x8421: LSB-first {0,5},{10,15}; MSB-first {15,10},{5,0}
      in_vec = 16'h8421; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat0("t1b1", 8'h50, 2'b11, 1'b0, 1'b0);
      chk("t1b1_in_ready", 32'(in_ready0), 32'd0);
      chk("d1b1_index", 32'(out_index1), 32'h00AF);
      chk("d1b1_last",  32'(out_last1),  32'd0);
      step();
      beat0("t1b2", 8'hFA, 2'b11, 1'b1, 1'b0);
      chk("t1b2_in_ready", 32'(in_ready0), 32'd1);
      chk("d1b2_index", 32'(out_index1), 32'h0005);
      chk("d1b2_mask",  32'(out_mask1),  32'd3);
      chk("d1b2_last",  32'(out_last1),  32'd1);

      // zero vector accepted while the last beat is consumed
      in_vec = 16'h0000; in_valid = 1'b1;
      step();
      beat0("t2", 8'h00, 2'b00, 1'b1, 1'b1);
      chk("t2_in_ready", 32'(in_ready0), 32'd1);

      // 0x0007 with backpressure
      in_vec = 16'h0007;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      beat0("t3b1", 8'h10, 2'b11, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         beat0("t3hold", 8'h10, 2'b11, 1'b0, 1'b0);
         chk("t3hold_in_ready", 32'(in_ready0), 32'd0);
      end
      out_ready = 1'b1;
      step();
      beat0("t3b2", 8'h02, 2'b01, 1'b1, 1'b0);
      step();
      chk("t3_idle_valid", 32'(out_valid0), 32'd0);
      chk("t3_idle_ready", 32'(in_ready0), 32'd1);

      // back-to-back 0x0003 then 0x0010
      in_vec = 16'h0003; in_valid = 1'b1;
      step();
      beat0("t4a", 8'h10, 2'b11, 1'b1, 1'b0);
      chk("t4a_in_ready", 32'(in_ready0), 32'd1);
      in_vec = 16'h0010;
      step();
      in_valid = 1'b0;
      beat0("t4b", 8'h04, 2'b01, 1'b1, 1'b0);
      step();
      chk("t4_idle_valid", 32'(out_valid0), 32'd0);

      // reset mid-vector, then 0x0002
      in_vec = 16'h8421; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat0("t5b1", 8'h50, 2'b11, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(out_valid0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_rel_valid", 32'(out_valid0), 32'd0);
      chk("t5_rel_ready", 32'(in_ready0), 32'd1);
      chk("t5_rel_valid_d1", 32'(out_valid1), 32'd0);
      in_vec = 16'h0002; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      beat0("t5n", 8'h01, 2'b01, 1'b1, 1'b0);
      chk("t5n_d1_index", 32'(out_index1), 32'h0001);
      step();
      chk("t5_end_valid", 32'(out_valid0), 32'd0);
      chk("t5_end_ready_d1", 32'(in_ready1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
